instruction_encode_loader: RTL and testbench

//  Inverse of instruction decode: packs field tuples (opcode, R_s, R_t, R_d, shamt, function_code, offset, address)

---
 rtl/instruction_encode_loader_if.sv | 29 ++
 rtl/instruction_encode_loader.sv | 118 +++++++++++
 tb/tb_instruction_encode_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_encode_loader_if.sv
// rtl/instruction_encode_loader_if.sv - field-tuple stream in, instruction-memory write port out
interface instruction_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        R_s;
    logic [4:0]        R_t;
    logic [4:0]        R_d;
    logic [4:0]        shamt;
    logic [5:0]        function_code;
    logic [15:0]       offset;
    logic [25:0]       address;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, fmt, opcode, R_s, R_t, R_d, shamt, function_code, offset, address,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, fmt, opcode, R_s, R_t, R_d, shamt, function_code, offset, address,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instruction_encode_loader.sv
// rtl/instruction_encode_loader.sv - packs R/I/J field tuples into 32-bit words and writes them to imem
module instruction_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [CNT_W-1:0]            instr_count,
    input  logic                        abort,
    instruction_encode_loader_if.slave  bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [CNT_W-1:0]            written
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       enc;

    always_comb begin
        enc = 32'd0;
        case (bus.fmt)
            2'b00:   enc = {bus.opcode, bus.R_s, bus.R_t, bus.R_d, bus.shamt, bus.function_code};
            2'b01:   enc = {bus.opcode, bus.R_s, bus.R_t, bus.offset};
            2'b10:   enc = {bus.opcode, bus.address};
            default: enc = 32'd0;
        endcase
    end

    // abort outranks both start and a transfer offered in the same cycle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        written_d = written_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    ptr_d     = base_addr;
                    rem_d     = instr_count;
                    written_d = '0;
                    err_d     = 1'b0;
                    state_d   = (instr_count != '0) ? S_LOAD : S_FINISH;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus.in_valid) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (bus.fmt == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        we_d      = 1'b1;
                        addr_d    = ptr_q;
                        wdata_d   = enc;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        written_d = written_q + CNT_W'(1);
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            written_q <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            written_q <= written_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FINISH);
    assign err            = err_q;
    assign written        = written_q;
endmodule

// File: tb/tb_instruction_encode_loader.sv
// tb/tb_instruction_encode_loader.sv - scoreboard bench for instruction_encode_loader
module tb_instruction_encode_loader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] instr_count = '0;
    logic       abort = 1'b0;
    logic       busy, done, err;
    logic [7:0] written;

    instruction_encode_loader_if #(.ADDR_W(8)) bus ();

    instruction_encode_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .instr_count (instr_count),
        .abort       (abort),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .written     (written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int last_done_cyc = 0;
    logic [7:0]  mdl_ptr;
    logic [39:0] sb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_enc(input logic [1:0] f, input logic [5:0] op,
            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
            input logic [5:0] fn, input logic [15:0] off, input logic [25:0] ad);
        logic [31:0] w;
        w = 32'(op) << 26;
        if (f == 2'b00) w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
        if (f == 2'b01) w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(off);
        if (f == 2'b10) w = w | 32'(ad);
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (bus.imem_we) begin
            last_we_cyc = cyc;
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 64'(bus.imem_addr), 64'hDEAD);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check_eq("imem_addr", 64'(bus.imem_addr), 64'(e[39:32]));
                check_eq("imem_wdata", 64'(bus.imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [7:0] b, input logic [7:0] n);
        start = 1'b1;
        base_addr = b;
        instr_count = n;
        tick();
        start = 1'b0;
        mdl_ptr = b;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
            input logic [15:0] off, input logic [25:0] ad, input logic [31:0] exp_word);
        bus.in_valid = 1'b1;
        bus.fmt = f;
        bus.opcode = op;
        bus.R_s = rs;
        bus.R_t = rt;
        bus.R_d = rd;
        bus.shamt = sh;
        bus.function_code = fn;
        bus.offset = off;
        bus.address = ad;
        if (f != 2'b11) begin
            sb.push_back({mdl_ptr, exp_word});
            mdl_ptr = mdl_ptr + 8'd1;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [1:0] f);
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] off;
        logic [25:0] ad;
        op = 6'($urandom); fn = 6'($urandom);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        off = 16'($urandom); ad = 26'($urandom);
        send(f, op, rs, rt, rd, sh, fn, off, ad, model_enc(f, op, rs, rt, rd, sh, fn, off, ad));
    endtask

    task automatic end_session(input string tag, input int exp_written, input logic exp_err,
            input int done_before);
        tick(); tick(); tick();
        check_eq({tag, "_written"}, 64'(written), 64'(exp_written));
        check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - done_before), 64'd1);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_pending_writes"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.in_valid = 1'b0;
        bus.fmt = '0; bus.opcode = '0; bus.R_s = '0; bus.R_t = '0; bus.R_d = '0;
        bus.shamt = '0; bus.function_code = '0; bus.offset = '0; bus.address = '0;
        tick(); tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check_eq("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check_eq("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check_eq("rst_written", 64'(written), 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: fixed R/I/J words
        d0 = done_cnt;
        start_session(8'h10, 8'd3);
        check_eq("t1_in_ready", 64'(bus.in_ready), 64'd1);
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h155, 32'h00221820);
        send(2'b01, 6'h08, 5'd1, 5'd2, 5'd7, 5'd9, 6'h3F, 16'hFFFF, 26'h0, 32'h2022FFFF);
        send(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hAAAA, 26'h0000400, 32'h08000400);
        end_session("t1", 3, 1'b0, d0);
        check_eq("t1_done_after_last_write", 64'(last_done_cyc - last_we_cyc <= 1 && last_done_cyc >= last_we_cyc), 64'd1);

        // 2: in_valid toggling
        d0 = done_cnt;
        start_session(8'h40, 8'd4);
        for (int i = 0; i < 4; i++) begin
            send_rand(2'($urandom_range(0, 2)));
            tick();
        end
        end_session("t2", 4, 1'b0, d0);

        // 3: illegal format in second slot
        d0 = done_cnt;
        start_session(8'h50, 8'd2);
        send_rand(2'b00);
        send_rand(2'b11);
        end_session("t3", 1, 1'b1, d0);

        // 4: address wrap; start also clears err
        d0 = done_cnt;
        start_session(8'hFF, 8'd2);
        check_eq("t4_err_cleared", 64'(err), 64'd0);
        send_rand(2'b01);
        send_rand(2'b10);
        end_session("t4", 2, 1'b0, d0);

        // 5: abort after first transfer
        d0 = done_cnt;
        start_session(8'h60, 8'd5);
        send_rand(2'b00);
        abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.fmt = 2'b01;
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("t5_busy_after_abort", 64'(busy), 64'd0);
        tick(); tick(); tick();
        check_eq("t5_written", 64'(written), 64'd1);
        check_eq("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t5_pending_writes", 64'(sb.size()), 64'd0);

        // 6a: zero-length session
        d0 = done_cnt;
        start_session(8'h70, 8'd0);
        check_eq("t6_done_now", 64'(done), 64'd1);
        tick();
        check_eq("t6_done_one_cycle", 64'(done), 64'd0);
        check_eq("t6_written", 64'(written), 64'd0);
        check_eq("t6_busy", 64'(busy), 64'd0);

        // 6b: start while busy is ignored
        d0 = done_cnt;
        start_session(8'h20, 8'd3);
        send_rand(2'b00);
        start = 1'b1;
        base_addr = 8'h80;
        instr_count = 8'd1;
        tick();
        start = 1'b0;
        send_rand(2'b01);
        send_rand(2'b10);
        end_session("t6b", 3, 1'b0, d0);

        // 6c: reset coinciding with a transfer drops that write
        d0 = done_cnt;
        start_session(8'h30, 8'd4);
        send_rand(2'b00);
        send_rand(2'b11);
        reset_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.fmt = 2'b10;
        tick();
        bus.in_valid = 1'b0;
        check_eq("t6c_busy", 64'(busy), 64'd0);
        check_eq("t6c_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("t6c_imem_we", 64'(bus.imem_we), 64'd0);
        check_eq("t6c_imem_addr", 64'(bus.imem_addr), 64'd0);
        check_eq("t6c_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check_eq("t6c_written", 64'(written), 64'd0);
        check_eq("t6c_err", 64'(err), 64'd0);
        reset_n = 1'b1;
        tick(); tick();
        check_eq("t6c_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t6c_pending_writes", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
